// File: rtl/serdes_word_aligner.sv
// rtl/serdes_word_aligner.sv - 8b/10b comma word aligner with lock acquisition and loss tracking
module serdes_word_aligner #(
    parameter int         ACQ_COMMAS = 3,
    parameter int         WIN        = 64,
    parameter int         MAX_ERR    = 4,
    parameter int         ERR_CNT_W  = 16,
    parameter logic [9:0] COMMA_N    = 10'b0101111100
) (
    input  logic                 bitclk,
    input  logic                 rst,
    input  logic                 sig_in,
    output logic [9:0]           word_out,
    output logic                 word_valid,
    output logic                 is_comma,
    output logic                 locked,
    output logic                 code_err,
    output logic                 disp_err,
    output logic                 realign,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int                WIN_W     = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int                WERR_W    = $clog2(MAX_ERR + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [WERR_W-1:0] ERR_LIMIT = WERR_W'(MAX_ERR);
    localparam logic [3:0]        ACQ_N     = 4'(ACQ_COMMAS);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [9:0]            sr_q, sr_d;
    logic [3:0]            ph_q, ph_d;
    logic [3:0]            comma_cnt_q, comma_cnt_d;
    logic                  rd_q, rd_d;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]     win_err_q, win_err_d;
    logic [9:0]            word_out_q, word_out_d;
    logic                  word_valid_q, word_valid_d;
    logic                  is_comma_q, is_comma_d;
    logic                  locked_q, locked_d;
    logic                  code_err_q, code_err_d;
    logic                  disp_err_q, disp_err_d;
    logic                  realign_q, realign_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

    logic [3:0] ones;
    logic       comma_hit;
    logic       boundary;
    logic       bad_code;
    logic       bad_disp;
    logic       rd_next;
    logic       err_word;

    // Classify the current shift-register contents as a candidate word (rd_q = 1 means RD+)
    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {3'b000, sr_q[i]};
        end
        comma_hit = (sr_q == COMMA_N) || (sr_q == ~COMMA_N);
        boundary  = (ph_q == 4'd9);
        bad_code  = (ones < 4'd4) || (ones > 4'd6);
        bad_disp  = ((ones == 4'd6) && rd_q) || ((ones == 4'd4) && !rd_q);
        rd_next   = (ones == 4'd6) ? 1'b1 : ((ones == 4'd4) ? 1'b0 : rd_q);
    end

    // Next-state logic for the HUNT / VERIFY / LOCKED alignment machine and its counters
    always_comb begin
        state_d      = state_q;
        sr_d         = {sig_in, sr_q[9:1]};
        ph_d         = boundary ? 4'd0 : ph_q + 4'd1;
        comma_cnt_d  = comma_cnt_q;
        rd_d         = rd_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        is_comma_d   = is_comma_q;
        code_err_d   = code_err_q;
        disp_err_d   = disp_err_q;
        realign_d    = 1'b0;
        err_count_d  = err_count_q;
        err_word     = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (comma_hit) begin
                    ph_d        = 4'd0;
                    rd_d        = rd_next;
                    comma_cnt_d = 4'd1;
                    win_cnt_d   = '0;
                    win_err_d   = '0;
                    state_d     = (ACQ_N == 4'd1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (bad_code || bad_disp) begin
                        state_d     = HUNT;
                        comma_cnt_d = 4'd0;
                    end else begin
                        rd_d = rd_next;
                        if (comma_hit) begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                            if (comma_cnt_q + 4'd1 >= ACQ_N) begin
                                state_d   = LOCKED;
                                win_cnt_d = '0;
                                win_err_d = '0;
                            end
                        end
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    word_out_d   = sr_q;
                    is_comma_d   = comma_hit;
                    code_err_d   = bad_code;
                    disp_err_d   = bad_disp;
                    word_valid_d = 1'b1;
                    rd_d         = rd_next;
                    err_word     = bad_code || bad_disp;
                end else if (comma_hit) begin
                    // A comma off the word grid means the phase has slipped
                    err_word = 1'b1;
                end
                // The wrap word opens the new window, so its own error lands there
                if (boundary && (win_cnt_q == WIN_LAST)) begin
                    win_cnt_d = '0;
                    win_err_d = WERR_W'(err_word);
                end else begin
                    if (boundary) begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                    win_err_d = win_err_q + WERR_W'(err_word);
                end
                if (err_word && (err_count_q != '1)) begin
                    err_count_d = err_count_q + ERR_CNT_W'(1);
                end
                if (win_err_d >= ERR_LIMIT) begin
                    state_d     = HUNT;
                    realign_d   = 1'b1;
                    win_cnt_d   = '0;
                    win_err_d   = '0;
                    comma_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs; rst clears everything including the partial word/window
    always_ff @(posedge bitclk) begin
        if (rst) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            ph_q         <= '0;
            comma_cnt_q  <= '0;
            rd_q         <= 1'b0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            is_comma_q   <= 1'b0;
            locked_q     <= 1'b0;
            code_err_q   <= 1'b0;
            disp_err_q   <= 1'b0;
            realign_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            ph_q         <= ph_d;
            comma_cnt_q  <= comma_cnt_d;
            rd_q         <= rd_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            is_comma_q   <= is_comma_d;
            locked_q     <= locked_d;
            code_err_q   <= code_err_d;
            disp_err_q   <= disp_err_d;
            realign_q    <= realign_d;
            err_count_q  <= err_count_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign is_comma   = is_comma_q;
    assign locked     = locked_q;
    assign code_err   = code_err_q;
    assign disp_err   = disp_err_q;
    assign realign    = realign_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_serdes_word_aligner.sv
// tb/tb_serdes_word_aligner.sv - self-checking bench for serdes_word_aligner
module tb_serdes_word_aligner;
    localparam logic [9:0] CN   = 10'b0101111100;
    localparam logic [9:0] CP   = 10'b1010000011;
    localparam logic [9:0] DA   = 10'b1010101010;
    localparam logic [9:0] DB   = 10'b0101010101;
    localparam logic [9:0] BADW = 10'b1111111000;

    logic        bitclk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic [9:0]  word_out;
    logic        word_valid;
    logic        is_comma;
    logic        locked;
    logic        code_err;
    logic        disp_err;
    logic        realign;
    logic [15:0] err_count;

    serdes_word_aligner dut (
        .bitclk    (bitclk),
        .rst       (rst),
        .sig_in    (sig_in),
        .word_out  (word_out),
        .word_valid(word_valid),
        .is_comma  (is_comma),
        .locked    (locked),
        .code_err  (code_err),
        .disp_err  (disp_err),
        .realign   (realign),
        .err_count (err_count)
    );

    always #5 bitclk = ~bitclk;

    typedef struct packed {
        logic [9:0]  w;
        logic        cm;
        logic        ce;
        logic        de;
        logic        cc;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [9:0] w;
        logic       ce;
        logic       de;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vt[11];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          sb_en   = 1'b0;
    bit          pol_g   = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    int          cyc = 0;
    int          lock_cyc = -1;
    int          valid_cyc = -1;
    int          realign_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sig_in = b;
        @(posedge bitclk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic push(input logic [9:0] w, input logic cm, input logic ce, input logic de, input logic cc);
        exp_t e;
        if ((ce || de) && (exp_cnt != 16'hFFFF)) exp_cnt++;
        e.w = w; e.cm = cm; e.ce = ce; e.de = de; e.cc = cc; e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_word_out"},   32'(word_out),   32'd0);
        chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
        chk({tag, "_is_comma"},   32'(is_comma),   32'd0);
        chk({tag, "_locked"},     32'(locked),     32'd0);
        chk({tag, "_code_err"},   32'(code_err),   32'd0);
        chk({tag, "_disp_err"},   32'(disp_err),   32'd0);
        chk({tag, "_realign"},    32'(realign),    32'd0);
        chk({tag, "_err_count"},  32'(err_count),  32'd0);
    endtask

    // Alternating commas until lock is observed; the first word seen locked is expected out
    task automatic acquire(input logic cc, output bit got, output int nw);
        logic [9:0] w;
        got = 1'b0;
        nw  = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            w = pol_g ? CP : CN;
            pol_g = ~pol_g;
            send_word(w);
            nw++;
            if (locked) begin
                sb_q.delete();
                sb_en = 1'b1;
                push(w, 1'b1, 1'b0, 1'b0, cc);
                got = 1'b1;
            end
        end
        chk("acquire_locked", 32'(got), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time bound expired before the test completed");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [9:0] w;
        bit         got;
        int         nw;
        int         rl0;
        logic       prev;
        int         run;
        logic       b;

        vt[0]  = '{10'b1010101010, 1'b0, 1'b0};
        vt[1]  = '{10'b0101010101, 1'b0, 1'b0};
        vt[2]  = '{10'b1111111000, 1'b1, 1'b0};
        vt[3]  = '{10'b1101101010, 1'b0, 1'b0};
        vt[4]  = '{10'b1100110010, 1'b0, 1'b0};
        vt[5]  = '{10'b0010010101, 1'b0, 1'b0};
        vt[6]  = '{10'b0010010101, 1'b0, 1'b1};
        vt[7]  = '{10'b1101101010, 1'b0, 1'b0};
        vt[8]  = '{10'b1101101010, 1'b0, 1'b1};
        vt[9]  = '{10'b0010010101, 1'b0, 1'b0};
        vt[10] = '{10'b1010101010, 1'b0, 1'b0};

        fork
            forever begin
                exp_t e;
                @(negedge bitclk);
                cyc++;
                if (!rst) begin
                    if (locked && lock_cyc < 0) lock_cyc = cyc;
                    if (word_valid && valid_cyc < 0) valid_cyc = cyc;
                    if (realign) realign_cnt++;
                    if (word_valid && sb_en) begin
                        if (sb_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL sb_unexpected: word_valid with word_out %b, required no valid", word_out);
                        end else begin
                            e = sb_q.pop_front();
                            chk("sb_word", 32'(word_out), 32'(e.w));
                            chk("sb_is_comma", 32'(is_comma), 32'(e.cm));
                            chk("sb_code_err", 32'(code_err), 32'(e.ce));
                            chk("sb_disp_err", 32'(disp_err), 32'(e.de));
                            if (e.cc) chk("sb_err_count", 32'(err_count), 32'(e.cnt));
                        end
                    end
                end
            end
        join_none

        rst = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(posedge bitclk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Random preamble with runs of at most 4 so no comma can appear in it
        prev = 1'b0;
        run  = 0;
        for (int i = 0; i < 57; i++) begin
            b = 1'(($urandom_range(0, 1)));
            if (b == prev && run == 4) b = ~prev;
            run  = (b == prev) ? run + 1 : 1;
            prev = b;
            send_bit(b);
        end
        chk("hunt_not_locked", 32'(locked), 32'd0);

        acquire(1'b1, got, nw);
        chk("acq_words", 32'(nw), 32'd4);

        for (int i = 0; i < 11; i++) begin
            push(vt[i].w, 1'b0, vt[i].ce, vt[i].de, 1'b1);
            send_word(vt[i].w);
        end
        chk("lock_to_valid_latency", 32'(valid_cyc - lock_cyc), 32'd10);
        chk("table_err_count", 32'(err_count), 32'd3);
        chk("table_locked", 32'(locked), 32'd1);

        // Three errors per window across windows 2..6 must not drop lock
        for (int n = 13; n < 384; n++) begin
            if (n >= 64 && ((n % 64) == 10 || (n % 64) == 20 || (n % 64) == 30)) begin
                w = BADW;
                push(w, 1'b0, 1'b1, 1'b0, 1'b1);
            end else begin
                w = (n % 2 == 1) ? DA : DB;
                push(w, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            send_word(w);
        end
        chk("hold_locked", 32'(locked), 32'd1);
        chk("hold_realign_none", 32'(realign_cnt), 32'd0);

        // Four errors in one window drop lock one cycle after the fourth
        for (int i = 0; i < 4; i++) begin
            push(BADW, 1'b0, 1'b1, 1'b0, 1'b1);
            send_word(BADW);
        end
        chk("loss_still_locked", 32'(locked), 32'd1);
        chk("loss_no_early_realign", 32'(realign), 32'd0);
        w = DA;
        for (int i = 0; i < 10; i++) begin
            send_bit(w[i]);
            if (i == 0) begin
                chk("loss_locked_low", 32'(locked), 32'd0);
                chk("loss_realign_high", 32'(realign), 32'd1);
            end
            if (i == 1) chk("loss_realign_one_cycle", 32'(realign), 32'd0);
        end
        chk("loss_err_count", 32'(err_count), 32'd22);
        send_word(DB);

        acquire(1'b1, got, nw);
        chk("reacq_words", 32'(nw), 32'd4);
        for (int i = 0; i < 3; i++) begin
            w = (i % 2 == 0) ? DA : DB;
            push(w, 1'b0, 1'b0, 1'b0, 1'b1);
            send_word(w);
        end

        // Slip the stream by three bits while locked
        rl0 = realign_cnt;
        send_bit(1'b0);
        sb_en = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        for (int k = 0; k < 10 && locked; k++) begin
            w = pol_g ? CP : CN;
            pol_g = ~pol_g;
            send_word(w);
        end
        chk("shift_lock_lost", 32'(locked), 32'd0);
        chk("shift_realign_seen", 32'(realign_cnt > rl0), 32'd1);
        chk("shift_errs_counted", 32'(err_count > 16'd22), 32'd1);
        acquire(1'b0, got, nw);
        for (int i = 0; i < 3; i++) begin
            w = (i % 2 == 0) ? DB : DA;
            push(w, 1'b0, 1'b0, 1'b0, 1'b0);
            send_word(w);
        end

        // Fresh run to five errors, then reset mid-word
        rst = 1'b1;
        @(posedge bitclk);
        #1;
        rst = 1'b0;
        exp_cnt = 16'd0;
        acquire(1'b1, got, nw);
        chk("rst_acq_words", 32'(nw), 32'd4);
        for (int n = 2; n < 68; n++) begin
            if (n == 5 || n == 6 || n == 7 || n == 65 || n == 66) begin
                w = BADW;
                push(w, 1'b0, 1'b1, 1'b0, 1'b1);
            end else begin
                w = (n % 2 == 1) ? DA : DB;
                push(w, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            send_word(w);
        end
        chk("pre_rst_err_count", 32'(err_count), 32'd5);
        chk("pre_rst_locked", 32'(locked), 32'd1);
        w = DA;
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        rl0 = realign_cnt;
        rst = 1'b1;
        @(posedge bitclk);
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        exp_cnt = 16'd0;
        acquire(1'b1, got, nw);
        chk("post_rst_acq_words", 32'(nw), 32'd4);
        chk("post_rst_no_realign", 32'(realign_cnt), 32'(rl0));
        push(DB, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(DB);
        repeat (3) @(posedge bitclk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
